// File: rtl/framebuffer_pkg.sv
// Shared definitions for the double-buffered framebuffer: default geometry,
// width helpers and the one-hot scanout state encoding.
package framebuffer_pkg;

    localparam int unsigned FB_WIDTH_DEF  = 400;
    localparam int unsigned FB_HEIGHT_DEF = 240;
    localparam int unsigned COLOR_W       = 16;

    // One-hot, matching the rest of the GPU's state machines.
    typedef enum logic [2:0] {
        SCAN_IDLE   = 3'b001,
        SCAN_STREAM = 3'b010,
        SCAN_DRAIN  = 3'b100
    } scan_state_t;

    // Coordinate ports carry one spare bit so out-of-range values are representable.
    function automatic int unsigned coord_width(input int unsigned extent);
        return $clog2(extent) + 1;
    endfunction

    function automatic int unsigned addr_width(input int unsigned depth);
        return (depth <= 1) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/fb_bank_ram.sv
// One pixel bank: simple dual-port RAM, one write port and one synchronous
// read port with single-cycle latency. Contents are not reset.
module fb_bank_ram
    import framebuffer_pkg::*;
#(
    parameter int unsigned DEPTH = FB_WIDTH_DEF * FB_HEIGHT_DEF,
    parameter int unsigned AW    = addr_width(FB_WIDTH_DEF * FB_HEIGHT_DEF),
    parameter int unsigned DW    = COLOR_W
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];

    // Write port and registered read port; plain clocked block for RAM inference.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/framebuffer.sv
// Double-buffered framebuffer: the GPU writes the back bank, the scanout
// engine streams the front bank in raster order over valid/ready, and bank
// swaps are deferred until no frame is being streamed.
module framebuffer
    import framebuffer_pkg::*;
#(
    parameter int unsigned FB_WIDTH  = FB_WIDTH_DEF,
    parameter int unsigned FB_HEIGHT = FB_HEIGHT_DEF
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [coord_width(FB_WIDTH)-1:0]    fb_x,
    input  logic [coord_width(FB_HEIGHT)-1:0]   fb_y,
    input  logic [15:0]                         fb_color,
    input  logic                                fb_write,
    input  logic                                swap_req,
    output logic                                swap_pending,
    output logic                                front_bank,
    input  logic                                scan_start,
    output logic                                scan_busy,
    output logic [coord_width(FB_WIDTH)-1:0]    scan_x,
    output logic [coord_width(FB_HEIGHT)-1:0]   scan_y,
    output logic [15:0]                         scan_color,
    output logic                                scan_valid,
    input  logic                                scan_ready,
    output logic                                scan_frame_done
);

    localparam int unsigned XW    = coord_width(FB_WIDTH);
    localparam int unsigned YW    = coord_width(FB_HEIGHT);
    localparam int unsigned DEPTH = FB_WIDTH * FB_HEIGHT;
    localparam int unsigned AW    = addr_width(DEPTH);

    scan_state_t   state, state_next;

    logic          wr_ok;
    logic [AW-1:0] wr_addr;
    logic          we0, we1;

    logic [XW-1:0] rx;
    logic [YW-1:0] ry;
    logic [AW-1:0] rd_addr;
    logic          scan_bank;
    logic          rd_issue;
    logic          drain_exit;
    logic [15:0]   rdata0, rdata1, rd_color;

    logic          rd_inflight;
    logic [XW-1:0] if_x;
    logic [YW-1:0] if_y;

    logic          out_valid;
    logic          spill_valid;
    logic [XW-1:0] spill_x;
    logic [YW-1:0] spill_y;
    logic [15:0]   spill_color;
    logic          pop;
    logic [1:0]    occ_after_pop;
    logic          buf_space;

    logic          swap_req_d;
    logic          swap_rise;
    logic          do_swap;

    // Write path: in-bounds writes go to the bank not currently at the front.
    assign wr_ok   = fb_write && (fb_x < XW'(FB_WIDTH)) && (fb_y < YW'(FB_HEIGHT));
    assign wr_addr = AW'(fb_y) * AW'(FB_WIDTH) + AW'(fb_x);
    assign we0     = wr_ok &&  front_bank;
    assign we1     = wr_ok && !front_bank;

    fb_bank_ram #(.DEPTH(DEPTH), .AW(AW), .DW(16)) u_bank0 (
        .clk   (clk),
        .we    (we0),
        .waddr (wr_addr),
        .wdata (fb_color),
        .re    (rd_issue),
        .raddr (rd_addr),
        .rdata (rdata0)
    );

    fb_bank_ram #(.DEPTH(DEPTH), .AW(AW), .DW(16)) u_bank1 (
        .clk   (clk),
        .we    (we1),
        .waddr (wr_addr),
        .wdata (fb_color),
        .re    (rd_issue),
        .raddr (rd_addr),
        .rdata (rdata1)
    );

    assign rd_color = scan_bank ? rdata1 : rdata0;

    // Reads are only issued while the in-flight read plus both buffer entries
    // (after this cycle's pop) leave room, so the spill entry never overflows.
    assign pop           = out_valid && scan_ready;
    assign occ_after_pop = 2'(out_valid) + 2'(spill_valid) + 2'(rd_inflight) - 2'(pop);
    assign buf_space     = (occ_after_pop < 2'd2);

    assign scan_valid = out_valid;
    assign scan_busy  = (state != SCAN_IDLE);

    assign swap_rise = swap_req && !swap_req_d;
    assign do_swap   = swap_pending && ((state == SCAN_IDLE) || drain_exit);

    // Scanout state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= SCAN_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Scanout next-state, read issue and drain completion.
    always_comb begin
        state_next = state;
        rd_issue   = 1'b0;
        drain_exit = 1'b0;
        unique case (state)
            SCAN_IDLE: begin
                if (scan_start) begin
                    state_next = SCAN_STREAM;
                end
            end
            SCAN_STREAM: begin
                rd_issue = buf_space;
                if (buf_space && (rx == XW'(FB_WIDTH - 1)) && (ry == YW'(FB_HEIGHT - 1))) begin
                    state_next = SCAN_DRAIN;
                end
            end
            SCAN_DRAIN: begin
                if (!out_valid && !spill_valid && !rd_inflight) begin
                    state_next = SCAN_IDLE;
                    drain_exit = 1'b1;
                end
            end
            default: state_next = SCAN_IDLE;
        endcase
    end

    // Raster read counters; the front bank is latched for the whole frame.
    // A swap executing on the same edge as scan_start still scans the old front.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx        <= '0;
            ry        <= '0;
            rd_addr   <= '0;
            scan_bank <= 1'b0;
        end else if ((state == SCAN_IDLE) && scan_start) begin
            rx        <= '0;
            ry        <= '0;
            rd_addr   <= '0;
            scan_bank <= front_bank;
        end else if (rd_issue) begin
            rd_addr <= rd_addr + 1'b1;
            if (rx == XW'(FB_WIDTH - 1)) begin
                rx <= '0;
                ry <= ry + 1'b1;
            end else begin
                rx <= rx + 1'b1;
            end
        end
    end

    // Coordinates travel alongside the read while the RAM produces its data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_inflight <= 1'b0;
            if_x        <= '0;
            if_y        <= '0;
        end else begin
            rd_inflight <= rd_issue;
            if (rd_issue) begin
                if_x <= rx;
                if_y <= ry;
            end
        end
    end

    // Two-entry skid: the output register refills from the spill entry first,
    // otherwise from the RAM; RAM data lands in spill when the output is stalled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid   <= 1'b0;
            scan_x      <= '0;
            scan_y      <= '0;
            scan_color  <= '0;
            spill_valid <= 1'b0;
            spill_x     <= '0;
            spill_y     <= '0;
            spill_color <= '0;
        end else if (!out_valid || pop) begin
            if (spill_valid) begin
                out_valid   <= 1'b1;
                scan_x      <= spill_x;
                scan_y      <= spill_y;
                scan_color  <= spill_color;
                spill_valid <= rd_inflight;
                if (rd_inflight) begin
                    spill_x     <= if_x;
                    spill_y     <= if_y;
                    spill_color <= rd_color;
                end
            end else if (rd_inflight) begin
                out_valid  <= 1'b1;
                scan_x     <= if_x;
                scan_y     <= if_y;
                scan_color <= rd_color;
            end else begin
                out_valid <= 1'b0;
            end
        end else if (rd_inflight) begin
            spill_valid <= 1'b1;
            spill_x     <= if_x;
            spill_y     <= if_y;
            spill_color <= rd_color;
        end
    end

    // Swap request edge detect, deferred bank toggle and frame-done pulse.
    // A new rising edge on the swap edge re-arms the request.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            swap_req_d      <= 1'b0;
            swap_pending    <= 1'b0;
            front_bank      <= 1'b0;
            scan_frame_done <= 1'b0;
        end else begin
            swap_req_d      <= swap_req;
            swap_pending    <= swap_rise || (swap_pending && !do_swap);
            scan_frame_done <= drain_exit;
            if (do_swap) begin
                front_bank <= !front_bank;
            end
        end
    end

endmodule

// File: tb/tb_framebuffer.sv
// Scoreboard bench for the framebuffer on a reduced 20x12 geometry.
module tb_framebuffer;
    import framebuffer_pkg::*;

    localparam int W  = 20;
    localparam int H  = 12;
    localparam int N  = W * H;
    localparam int XW = $clog2(W) + 1;
    localparam int YW = $clog2(H) + 1;

    logic          clk = 1'b0;
    logic          reset;
    logic [XW-1:0] fb_x;
    logic [YW-1:0] fb_y;
    logic [15:0]   fb_color;
    logic          fb_write;
    logic          swap_req;
    logic          swap_pending;
    logic          front_bank;
    logic          scan_start;
    logic          scan_busy;
    logic [XW-1:0] scan_x;
    logic [YW-1:0] scan_y;
    logic [15:0]   scan_color;
    logic          scan_valid;
    logic          scan_ready;
    logic          scan_frame_done;

    framebuffer #(.FB_WIDTH(W), .FB_HEIGHT(H)) dut (
        .clk             (clk),
        .reset           (reset),
        .fb_x            (fb_x),
        .fb_y            (fb_y),
        .fb_color        (fb_color),
        .fb_write        (fb_write),
        .swap_req        (swap_req),
        .swap_pending    (swap_pending),
        .front_bank      (front_bank),
        .scan_start      (scan_start),
        .scan_busy       (scan_busy),
        .scan_x          (scan_x),
        .scan_y          (scan_y),
        .scan_color      (scan_color),
        .scan_valid      (scan_valid),
        .scan_ready      (scan_ready),
        .scan_frame_done (scan_frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          x;
        int          y;
        logic [15:0] c;
    } pix_t;

    pix_t        q[$];
    logic [15:0] mem [2][N];
    int          mfront;
    int          checks    = 0;
    int          failures  = 0;
    int          xfers     = 0;
    int          done_cnt  = 0;
    int          done_base = 0;
    int          xfer_base = 0;
    bit          rdy_rand  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Consumer readiness: always ready, or ready on roughly 30% of cycles.
    always @(posedge clk) begin
        #1;
        scan_ready = rdy_rand ? ($urandom_range(0, 99) < 30) : 1'b1;
    end

    // Monitor: pops the expected pixel on every transfer and checks stall stability.
    bit          held = 1'b0;
    logic [XW-1:0] h_x;
    logic [YW-1:0] h_y;
    logic [15:0]   h_c;
    always @(negedge clk) begin
        if (reset) begin
            held = 1'b0;
        end else begin
            if (held) begin
                check("stall_valid", 32'(scan_valid), 32'd1);
                check("stall_x", 32'(scan_x), 32'(h_x));
                check("stall_y", 32'(scan_y), 32'(h_y));
                check("stall_color", 32'(scan_color), 32'(h_c));
            end
            if (scan_valid && scan_ready) begin
                xfers++;
                if (q.size() == 0) begin
                    check("unexpected_pixel", 32'(xfers), 32'd0);
                end else begin
                    pix_t e;
                    e = q.pop_front();
                    check("pix_x", 32'(scan_x), 32'(e.x));
                    check("pix_y", 32'(scan_y), 32'(e.y));
                    check("pix_color", 32'(scan_color), 32'(e.c));
                end
            end
            held = scan_valid && !scan_ready;
            h_x  = scan_x;
            h_y  = scan_y;
            h_c  = scan_color;
            if (scan_frame_done) done_cnt++;
        end
    end

    task automatic wr(input int x, input int y, input logic [15:0] c);
        fb_x     = XW'(x);
        fb_y     = YW'(y);
        fb_color = c;
        fb_write = 1'b1;
        if (x < W && y < H) mem[1 - mfront][y * W + x] = c;
        @(posedge clk); #1;
        fb_write = 1'b0;
    endtask

    task automatic fill_back();
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                wr(x, y, 16'($urandom));
    endtask

    task automatic swap_idle();
        swap_req = 1'b1;
        @(posedge clk); #1;
        check("swap_pending_set", 32'(swap_pending), 32'd1);
        swap_req = 1'b0;
        @(posedge clk); #1;
        check("swap_front", 32'(front_bank), 32'(1 - mfront));
        check("swap_pending_clr", 32'(swap_pending), 32'd0);
        mfront = 1 - mfront;
    endtask

    task automatic start_frame();
        int lat;
        for (int i = 0; i < N; i++) q.push_back('{i % W, i / W, mem[mfront][i]});
        done_base  = done_cnt;
        xfer_base  = xfers;
        scan_start = 1'b1;
        @(posedge clk); #1;
        scan_start = 1'b0;
        lat = 0;
        while (!scan_valid && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        check("first_valid_latency", 32'(lat), 32'd2);
    endtask

    task automatic wait_xfers(input int target);
        int n;
        n = 0;
        while (xfers < target && n < 5000) begin
            @(posedge clk); #1;
            n++;
        end
        check("xfer_wait_timeout", 32'(xfers >= target), 32'd1);
    endtask

    task automatic wait_frame(input bit watch_swap);
        int n;
        n = 0;
        while (done_cnt == done_base && n < N * 20 + 100) begin
            @(posedge clk); #1;
            if (watch_swap && scan_busy) begin
                check("pending_during_scan", 32'(swap_pending), 32'd1);
                check("front_during_scan", 32'(front_bank), 32'(mfront));
            end
            n++;
        end
        check("frame_done_timeout", 32'(done_cnt != done_base), 32'd1);
        repeat (3) @(posedge clk);
        #1;
        check("frame_done_once", 32'(done_cnt - done_base), 32'd1);
        check("transfer_count", 32'(xfers - xfer_base), 32'(N));
        check("queue_empty", 32'(q.size()), 32'd0);
        check("idle_after_frame", 32'(scan_busy), 32'd0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        reset      = 1'b1;
        fb_x       = '0;
        fb_y       = '0;
        fb_color   = '0;
        fb_write   = 1'b0;
        swap_req   = 1'b0;
        scan_start = 1'b0;
        scan_ready = 1'b1;
        mfront     = 0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_front_bank", 32'(front_bank), 32'd0);
        check("rst_swap_pending", 32'(swap_pending), 32'd0);
        check("rst_scan_busy", 32'(scan_busy), 32'd0);
        check("rst_scan_valid", 32'(scan_valid), 32'd0);
        check("rst_frame_done", 32'(scan_frame_done), 32'd0);
        check("rst_scan_xy", 32'({scan_x, scan_y}), 32'd0);
        check("rst_scan_color", 32'(scan_color), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;

        // Corner pixels into bank 1, swap, scan at full rate.
        fill_back();
        wr(0, 0, 16'h1234);
        wr(W - 1, H - 1, 16'hABCD);
        swap_idle();
        fill_back();
        rdy_rand = 1'b0;
        start_frame();
        wait_frame(1'b0);

        // Out-of-bounds writes must not alias into the bank; scan with stalls.
        wr(W, 5, 16'hFFFF);
        wr(5, H, 16'hFFFF);
        wr((1 << XW) - 1, (1 << YW) - 1, 16'hFFFF);
        swap_idle();
        rdy_rand = 1'b1;
        start_frame();
        wait_frame(1'b0);

        // Swap requested mid-frame (twice) is deferred to frame end and happens once.
        start_frame();
        wait_xfers(xfer_base + 100);
        swap_req = 1'b1;
        @(posedge clk); #1;
        swap_req = 1'b0;
        check("midframe_pending", 32'(swap_pending), 32'd1);
        for (int i = 0; i < 4; i++) wr($urandom_range(0, W - 1), $urandom_range(0, H - 1), 16'($urandom));
        swap_req = 1'b1;
        @(posedge clk); #1;
        swap_req = 1'b0;
        wait_frame(1'b1);
        check("midframe_front_after", 32'(front_bank), 32'(1 - mfront));
        check("midframe_pending_after", 32'(swap_pending), 32'd0);
        mfront = 1 - mfront;

        // Write on the same edge as an idle swap lands in the new front bank.
        swap_req = 1'b1;
        @(posedge clk); #1;
        check("coswap_pending", 32'(swap_pending), 32'd1);
        swap_req = 1'b0;
        wr(3, 4, 16'h5A5B);
        check("coswap_front", 32'(front_bank), 32'(1 - mfront));
        check("coswap_pending_clr", 32'(swap_pending), 32'd0);
        mfront = 1 - mfront;
        start_frame();
        wait_frame(1'b0);

        // Asynchronous reset in the middle of a frame, then a clean restart.
        swap_idle();
        rdy_rand = 1'b0;
        start_frame();
        wait_xfers(xfer_base + 100);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("midrst_valid", 32'(scan_valid), 32'd0);
        check("midrst_busy", 32'(scan_busy), 32'd0);
        check("midrst_front", 32'(front_bank), 32'd0);
        check("midrst_pending", 32'(swap_pending), 32'd0);
        check("midrst_xy", 32'({scan_x, scan_y}), 32'd0);
        q.delete();
        mfront = 0;
        repeat (2) @(negedge clk);
        #2;
        reset = 1'b0;
        check("midrst_no_done", 32'(done_cnt - done_base), 32'd0);
        @(posedge clk); #1;
        rdy_rand = 1'b1;
        start_frame();
        wait_frame(1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
